// File: rtl/fir_serial_mac.sv
// Serial-MAC FIR filter: one shared multiplier walks the N_TAPS taps after each
// accepted sample, then the shifted, saturated sum is presented for one cycle.
module fir_serial_mac #(
  parameter int N_TAPS  = 4,
  parameter int BW_IN   = 4,
  parameter int BW_COEF = 4,
  parameter int BW_OUT  = 8,
  parameter int SHIFT   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BW_IN-1:0]   x_in,
  input  logic               x_valid,
  input  logic               coef_load,
  input  logic [BW_COEF-1:0] coef_in,
  output logic [BW_OUT-1:0]  y_out,
  output logic               y_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int PROD_W = BW_IN + BW_COEF;
  localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
  localparam int KW     = $clog2(N_TAPS);
  localparam int EXT_W  = (ACC_W > BW_OUT) ? ACC_W : BW_OUT;
  localparam int LAST   = N_TAPS - 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX =
    {{(EXT_W-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN =
    {{(EXT_W-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_next;

  logic signed [BW_IN-1:0]   x_d  [N_TAPS];
  logic signed [BW_COEF-1:0] coef [N_TAPS];
  logic [KW-1:0]             k;
  logic signed [ACC_W-1:0]   acc;

  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   acc_shift;
  logic signed [EXT_W-1:0]   acc_ext;
  logic signed [BW_OUT-1:0]  y_sat;
  logic                      accept;
  logic                      load;
  logic                      last_tap;

  // Sample and coefficient inputs are only honoured in IDLE; a sample wins over a load.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    load       = 1'b0;
    last_tap   = 1'b0;
    case (state)
      IDLE: begin
        if (x_valid) begin
          accept     = 1'b1;
          state_next = MAC;
        end else if (coef_load) begin
          load = 1'b1;
        end
      end
      MAC: begin
        last_tap = (k == KW'(LAST));
        if (last_tap) state_next = OUT;
      end
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign prod      = coef[k] * x_d[k];
  assign acc_sum   = acc + ACC_W'(prod);
  assign acc_shift = acc_sum >>> SHIFT;
  assign acc_ext   = EXT_W'(acc_shift);

  always_comb begin
    if (acc_ext > SAT_MAX)      y_sat = SAT_MAX[BW_OUT-1:0];
    else if (acc_ext < SAT_MIN) y_sat = SAT_MIN[BW_OUT-1:0];
    else                        y_sat = acc_ext[BW_OUT-1:0];
  end

  // y_out is loaded on the final MAC edge so it is already valid during OUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        x_d[i]  <= '0;
        coef[i] <= '0;
      end
      acc     <= '0;
      k       <= '0;
      y_out   <= '0;
      overrun <= 1'b0;
    end else begin
      if (x_valid && (state != IDLE)) overrun <= 1'b1;
      if (accept) begin
        x_d[0] <= x_in;
        for (int i = 1; i < N_TAPS; i++) x_d[i] <= x_d[i-1];
        acc <= '0;
        k   <= '0;
      end
      if (load) begin
        for (int i = 0; i < N_TAPS - 1; i++) coef[i] <= coef[i+1];
        coef[LAST] <= coef_in;
      end
      if (state == MAC) begin
        acc <= acc_sum;
        if (last_tap) begin
          k     <= '0;
          y_out <= y_sat;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  assign y_valid = (state == OUT);
  assign busy    = (state != IDLE);

endmodule

// File: doc/fir_serial_mac.md
FIR_SERIAL_MAC -- requirements
Module: fir_serial_mac

Interface
REQ-001 SHALL have parameter N_TAPS, default 4: number of filter taps, 2..16.
REQ-002 SHALL have parameter BW_IN, default 4: signed two's-complement sample width.
REQ-003 SHALL have parameter BW_COEF, default 4: signed two's-complement coefficient width.
REQ-004 SHALL have parameter BW_OUT, default 8: signed output width.
REQ-005 SHALL have parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port x_in, input, BW_IN: new input sample.
REQ-009 SHALL have port x_valid, input, 1: x_in is presented this cycle.
REQ-010 SHALL have port coef_load, input, 1: shift coef_in into the coefficient register.
REQ-011 SHALL have port coef_in, input, BW_COEF: coefficient value.
REQ-012 SHALL have port y_out, output, BW_OUT: filtered, saturated result.
REQ-013 SHALL have port y_valid, output, 1: one-cycle pulse marking a new y_out.
REQ-014 SHALL have port busy, output, 1: high when not in IDLE.
REQ-015 SHALL have port overrun, output, 1: sticky flag for a dropped sample.

Function
REQ-016 SHALL keep an N_TAPS sample delay line x_d[0..N_TAPS-1], with x_d[0] the newest sample, and coefficient registers coef[0..N_TAPS-1].
REQ-017 SHALL implement y[n] = sat(( sum over k of coef[k]*x_d[k] ) >>> SHIFT), using one multiplier shared over N_TAPS cycles.
REQ-018 SHALL use a signed accumulator of width BW_IN+BW_COEF+clog2(N_TAPS), so that no intermediate result overflows.
REQ-019 SHALL saturate after the shift: values above 2^(BW_OUT-1)-1 clamp to that value, and values below -2^(BW_OUT-1) clamp to that value.
REQ-020 SHALL have FSM states IDLE, MAC and OUT.
REQ-021 In IDLE with x_valid=1, SHALL shift the delay line (x_d[0]<=x_in, x_d[k]<=x_d[k-1]), clear the accumulator, set the tap index to 0 and go to MAC.
REQ-022 In MAC, SHALL add coef[k]*x_d[k] to the accumulator each cycle and increment k; after k=N_TAPS-1 it SHALL go to OUT.
REQ-023 In OUT, SHALL register the saturated result into y_out, drive y_valid=1 for exactly that cycle, and return to IDLE.
REQ-024 Latency: x_valid accepted at cycle t SHALL give y_valid at cycle t+N_TAPS+1; the minimum sample spacing is N_TAPS+2 cycles.
REQ-025 y_out SHALL hold its value between OUT cycles.
REQ-026 x_valid while busy=1 SHALL be dropped, leave the delay line unchanged, and set overrun=1 until reset.
REQ-027 In IDLE with coef_load=1 and x_valid=0, SHALL shift the coefficients: coef[k]<=coef[k+1], coef[N_TAPS-1]<=coef_in.
REQ-028 coef_load while busy=1 SHALL be ignored; coefficients are never modified during a computation.
REQ-029 x_valid and coef_load high in the same IDLE cycle: the sample SHALL be accepted and coef_load ignored.

Reset
REQ-030 reset=1 SHALL force IDLE and clear x_d, coef, the accumulator, the tap index, y_out, y_valid, busy and overrun to 0, overriding all other inputs.
REQ-031 reset asserted during MAC or OUT SHALL abort the computation; no y_valid pulse follows, and the first sample after reset is processed normally.

Verification (N_TAPS=4, BW_IN=4, BW_COEF=4, BW_OUT=8, SHIFT=0)
REQ-032 Impulse: load coefficients 1,2,3,4 in that order, then send samples 1,0,0,0,0 spaced 6 cycles apart -> y_out = 1,2,3,4,0, each y_valid exactly 5 cycles after its x_valid.
REQ-033 Positive saturation: all coefficients 7, four samples of 7 -> 4th y_out = 127 (unsaturated 196); negative: all samples -8 -> 4th y_out = -128 (unsaturated -224).
REQ-034 Overrun: x_valid at cycle t and again at t+2 -> second sample dropped, overrun=1 from t+3, only one y_valid, delay line holds one new sample.
REQ-035 Load gating: coef_load during MAC with coef_in=5 -> coefficients unchanged and current y_out unaffected; x_valid with coef_load in IDLE -> sample taken, coefficients unchanged.
REQ-036 Mid-operation reset: reset one cycle during MAC -> no y_valid, y_out=0, overrun=0, all coefficients 0; the next sample gives y_out=0.
